// File: rtl/bcd_operand_reg.sv
// Signed BCD operand register with keypad editing and an iterative BCD-to-binary converter.
module bcd_operand_reg #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BINW   = 14
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [3:0]            digit,
    input  logic                  load,
    input  logic                  bksp,
    input  logic                  clear,
    input  logic                  negate,
    input  logic                  recall,
    input  logic [4*DIGITS-1:0]   recall_bcd,
    input  logic                  recall_neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic [3:0]            count,
    output logic                  full,
    output logic                  reject,
    output logic [DIGITS-1:0]     blank_mask,
    output logic [BINW-1:0]       bin,
    output logic                  bin_valid,
    output logic                  busy
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

    // Reject illegal parameter combinations at elaboration
    if ((DIGITS < 1) || (DIGITS > 8) ||
        ((BINW < 64) && ((64'(1) << BINW) <= MAX_VAL))) begin : g_bad_params
        $error("bcd_operand_reg: DIGITS must be 1..8 and 2**BINW must exceed 10**DIGITS-1");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [BINW-1:0] acc;
    logic [IW-1:0]   idx;

    logic [BW-1:0]   bcd_d;
    logic            neg_d;
    logic [CW-1:0]   count_d;
    logic            reject_d;
    logic [CW-1:0]   recall_count;
    logic            edit;
    logic [3:0]      nib;
    logic [BINW-1:0] acc_step;

    // Significant-digit count of the recall value
    always_comb begin
        recall_count = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (recall_bcd[4*i +: 4] != 4'h0) recall_count = CW'(i + 1);
        end
    end

    // Prioritised command decode: clear > recall > load > bksp > negate
    always_comb begin
        bcd_d    = bcd;
        neg_d    = neg;
        count_d  = count;
        reject_d = 1'b0;
        if (clear) begin
            bcd_d   = '0;
            neg_d   = 1'b0;
            count_d = '0;
        end else if (recall) begin
            bcd_d   = recall_bcd;
            neg_d   = recall_neg && (recall_bcd != '0);
            count_d = recall_count;
        end else if (load) begin
            if ((digit > 4'd9) || full) begin
                reject_d = 1'b1;
            end else if (!((digit == 4'h0) && (count == '0))) begin
                bcd_d   = BW'({bcd, digit});
                count_d = CW'(count + 4'd1);
            end
        end else if (bksp) begin
            if (count != '0) begin
                bcd_d   = bcd >> 4;
                count_d = CW'(count - 4'd1);
                if (count == CW'(1)) neg_d = 1'b0;
            end
        end else if (negate) begin
            if (count != '0) neg_d = ~neg;
        end
    end

    // Any change to the magnitude restarts the conversion
    assign edit = (bcd_d != bcd);

    // Operand state registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bcd    <= '0;
            neg    <= 1'b0;
            count  <= '0;
            reject <= 1'b0;
        end else begin
            bcd    <= bcd_d;
            neg    <= neg_d;
            count  <= count_d;
            reject <= reject_d;
        end
    end

    // Digit selected by the converter index
    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) nib = bcd[4*i +: 4];
        end
    end

    assign acc_step = BINW'((acc << 3) + (acc << 1) + BINW'(nib));

    // Converter: one digit per cycle, most significant first
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            bin       <= '0;
            bin_valid <= 1'b1;
            busy      <= 1'b0;
        end else if (edit) begin
            state     <= RUN;
            acc       <= '0;
            idx       <= IW'(DIGITS - 1);
            bin_valid <= 1'b0;
            busy      <= 1'b1;
        end else if (state == RUN) begin
            if (idx == '0) begin
                state     <= IDLE;
                acc       <= '0;
                bin       <= acc_step;
                bin_valid <= 1'b1;
                busy      <= 1'b0;
            end else begin
                acc <= acc_step;
                idx <= IW'(idx - 1'b1);
            end
        end
    end

    // Display helpers derived from the digit count
    assign full = (count == CW'(DIGITS));

    always_comb begin
        blank_mask = '0;
        for (int i = 0; i < DIGITS; i++) begin
            blank_mask[i] = (CW'(i) >= count) && (i != 0);
        end
    end

endmodule

// File: tb/tb_bcd_operand_reg.sv
// Directed self-checking bench for bcd_operand_reg (4-digit and 8-digit instances).
module tb_bcd_operand_reg;

    logic        clock;
    logic        resetn;
    logic [3:0]  digit;
    logic        load, bksp, clear, negate, recall, recall_neg;
    logic [15:0] recall_bcd;
    logic [15:0] bcd;
    logic        neg, full, reject, bin_valid, busy;
    logic [3:0]  count;
    logic [3:0]  blank_mask;
    logic [13:0] bin;

    logic [3:0]  digit_b;
    logic        load_b;
    logic        zero_b;
    logic [31:0] recall_bcd_b;
    logic [31:0] bcd_b;
    logic        neg_b, full_b, reject_b, bin_valid_b, busy_b;
    logic [3:0]  count_b;
    logic [7:0]  blank_mask_b;
    logic [26:0] bin_b;

    int n_cmp = 0;
    int n_err = 0;

    bcd_operand_reg dut (
        .clock(clock), .resetn(resetn), .digit(digit), .load(load), .bksp(bksp),
        .clear(clear), .negate(negate), .recall(recall), .recall_bcd(recall_bcd),
        .recall_neg(recall_neg), .bcd(bcd), .neg(neg), .count(count), .full(full),
        .reject(reject), .blank_mask(blank_mask), .bin(bin), .bin_valid(bin_valid),
        .busy(busy)
    );

    bcd_operand_reg #(.DIGITS(8), .BINW(27)) dut8 (
        .clock(clock), .resetn(resetn), .digit(digit_b), .load(load_b), .bksp(zero_b),
        .clear(zero_b), .negate(zero_b), .recall(zero_b), .recall_bcd(recall_bcd_b),
        .recall_neg(zero_b), .bcd(bcd_b), .neg(neg_b), .count(count_b), .full(full_b),
        .reject(reject_b), .blank_mask(blank_mask_b), .bin(bin_b), .bin_valid(bin_valid_b),
        .busy(busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // One cycle of strobes, then all strobes dropped
    task automatic cmd(input logic l, input logic b, input logic c, input logic n,
                       input logic r, input logic [3:0] d);
        load = l; bksp = b; clear = c; negate = n; recall = r; digit = d;
        tick();
        load = 1'b0; bksp = 1'b0; clear = 1'b0; negate = 1'b0; recall = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        digit = 4'h0; load = 1'b0; bksp = 1'b0; clear = 1'b0; negate = 1'b0;
        recall = 1'b0; recall_neg = 1'b0; recall_bcd = 16'h0;
        digit_b = 4'h0; load_b = 1'b0; zero_b = 1'b0; recall_bcd_b = 32'h0;

        // Reset state
        ticks(2);
        chk("rst_bcd", 64'(bcd), 64'h0);
        chk("rst_neg", 64'(neg), 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_reject", 64'(reject), 64'h0);
        chk("rst_blank", 64'(blank_mask), 64'he);
        chk("rst_bin", 64'(bin), 64'h0);
        chk("rst_valid", 64'(bin_valid), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        resetn = 1'b1;
        tick();

        // 1: enter 1234, conversion after exactly 4 cycles
        cmd(1, 0, 0, 0, 0, 4'd1);
        chk("t1_busy_first", 64'(busy), 64'h1);
        cmd(1, 0, 0, 0, 0, 4'd2);
        cmd(1, 0, 0, 0, 0, 4'd3);
        cmd(1, 0, 0, 0, 0, 4'd4);
        chk("t1_bcd", 64'(bcd), 64'h1234);
        chk("t1_count", 64'(count), 64'd4);
        chk("t1_full", 64'(full), 64'h1);
        chk("t1_blank", 64'(blank_mask), 64'h0);
        ticks(3);
        chk("t1_valid_early", 64'(bin_valid), 64'h0);
        tick();
        chk("t1_bin", 64'(bin), 64'd1234);
        chk("t1_valid", 64'(bin_valid), 64'h1);
        chk("t1_busy_done", 64'(busy), 64'h0);

        // 2: load while full, then bad digit after backspace
        cmd(1, 0, 0, 0, 0, 4'd5);
        chk("t2_reject_full", 64'(reject), 64'h1);
        chk("t2_bcd_kept", 64'(bcd), 64'h1234);
        chk("t2_no_conv", 64'(busy), 64'h0);
        tick();
        chk("t2_reject_pulse", 64'(reject), 64'h0);
        cmd(0, 1, 0, 0, 0, 4'd0);
        chk("t2_bksp_bcd", 64'(bcd), 64'h0123);
        cmd(1, 0, 0, 0, 0, 4'hA);
        chk("t2_reject_bad", 64'(reject), 64'h1);
        chk("t2_bcd", 64'(bcd), 64'h0123);
        chk("t2_count", 64'(count), 64'd3);
        chk("t2_blank", 64'(blank_mask), 64'h8);
        ticks(3);
        chk("t2_bin", 64'(bin), 64'd123);
        chk("t2_valid", 64'(bin_valid), 64'h1);

        // 3: leading zeros suppressed, negate, backspace to empty
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        tick();
        cmd(1, 0, 0, 0, 0, 4'd0);
        chk("t3_lz_count", 64'(count), 64'd0);
        chk("t3_lz_reject", 64'(reject), 64'h0);
        chk("t3_lz_busy", 64'(busy), 64'h0);
        cmd(1, 0, 0, 0, 0, 4'd0);
        cmd(1, 0, 0, 0, 0, 4'd7);
        chk("t3_bcd", 64'(bcd), 64'h0007);
        chk("t3_count", 64'(count), 64'd1);
        chk("t3_blank", 64'(blank_mask), 64'he);
        chk("t3_reject", 64'(reject), 64'h0);
        ticks(4);
        chk("t3_bin", 64'(bin), 64'd7);
        cmd(0, 0, 0, 1, 0, 4'd0);
        chk("t3_neg", 64'(neg), 64'h1);
        chk("t3_neg_valid", 64'(bin_valid), 64'h1);
        chk("t3_neg_busy", 64'(busy), 64'h0);
        cmd(0, 1, 0, 0, 0, 4'd0);
        chk("t3_bk_count", 64'(count), 64'd0);
        chk("t3_bk_neg", 64'(neg), 64'h0);
        chk("t3_bk_bcd", 64'(bcd), 64'h0);
        ticks(4);
        chk("t3_bk_bin", 64'(bin), 64'd0);

        // 4: edit while busy restarts, no partial result
        cmd(1, 0, 0, 0, 0, 4'd9);
        cmd(1, 0, 0, 0, 0, 4'd8);
        chk("t4_bcd", 64'(bcd), 64'h0098);
        ticks(3);
        chk("t4_no_partial_bin", 64'(bin), 64'd0);
        chk("t4_no_partial_valid", 64'(bin_valid), 64'h0);
        tick();
        chk("t4_bin", 64'(bin), 64'd98);
        chk("t4_valid", 64'(bin_valid), 64'h1);

        // 5: command priority, recall, zero recall forces positive
        cmd(0, 0, 1, 0, 0, 4'd0);
        cmd(1, 0, 0, 0, 0, 4'd4);
        cmd(1, 0, 0, 0, 0, 4'd2);
        ticks(4);
        chk("t5_bin42", 64'(bin), 64'd42);
        recall_bcd = 16'h1111; recall_neg = 1'b1;
        cmd(1, 0, 1, 0, 1, 4'd3);
        chk("t5_prio_bcd", 64'(bcd), 64'h0);
        chk("t5_prio_count", 64'(count), 64'd0);
        chk("t5_prio_neg", 64'(neg), 64'h0);
        ticks(4);
        recall_bcd = 16'h0305; recall_neg = 1'b1;
        cmd(0, 0, 0, 0, 1, 4'd0);
        chk("t5_rc_count", 64'(count), 64'd3);
        chk("t5_rc_neg", 64'(neg), 64'h1);
        chk("t5_rc_blank", 64'(blank_mask), 64'h8);
        ticks(3);
        chk("t5_rc_valid_early", 64'(bin_valid), 64'h0);
        tick();
        chk("t5_rc_bin", 64'(bin), 64'd305);
        recall_bcd = 16'h0000; recall_neg = 1'b1;
        cmd(0, 0, 0, 0, 1, 4'd0);
        chk("t5_rc0_neg", 64'(neg), 64'h0);
        chk("t5_rc0_count", 64'(count), 64'd0);
        cmd(0, 0, 0, 1, 0, 4'd0);
        chk("t5_neg_empty", 64'(neg), 64'h0);
        cmd(1, 1, 0, 1, 0, 4'd5);
        chk("t5_load_wins_bcd", 64'(bcd), 64'h0005);
        chk("t5_load_wins_neg", 64'(neg), 64'h0);
        ticks(4);
        chk("t5_bin5", 64'(bin), 64'd5);

        // 6: asynchronous reset mid-conversion
        cmd(1, 0, 0, 0, 0, 4'd3);
        ticks(2);
        chk("t6_busy", 64'(busy), 64'h1);
        chk("t6_bin_hold", 64'(bin), 64'd5);
        resetn = 1'b0;
        #2;
        chk("t6_rst_bin", 64'(bin), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'h0);
        chk("t6_rst_valid", 64'(bin_valid), 64'h1);
        chk("t6_rst_bcd", 64'(bcd), 64'h0);
        resetn = 1'b1;
        tick();

        // 6b: eight-digit instance, 99999999
        for (int i = 0; i < 8; i++) begin
            digit_b = 4'd9; load_b = 1'b1;
            tick();
            load_b = 1'b0;
        end
        chk("t6b_bcd", 64'(bcd_b), 64'h99999999);
        chk("t6b_count", 64'(count_b), 64'd8);
        chk("t6b_full", 64'(full_b), 64'h1);
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
        chk("t6b_reject", 64'(reject_b), 64'h1);
        ticks(6);
        chk("t6b_valid_early", 64'(bin_valid_b), 64'h0);
        tick();
        chk("t6b_bin", 64'(bin_b), 64'd99999999);
        chk("t6b_valid", 64'(bin_valid_b), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_operand_reg.md
Name: bcd_operand_reg

Overview:
- Parametrised successor to the calculator's fixed-width BCD operand register.
- Holds a DIGITS-wide signed BCD operand entered digit-by-digit from the keypad handler.
- Supports backspace, clear, sign toggle and memory recall, and reports digit count, full and reject status plus a leading-zero blank mask for the display mux.
- Contains an iterative BCD-to-binary converter with busy/valid handshake, which replaces the combinational converter in front of the ALU.

Parameters:
- DIGITS, 4: number of BCD digits held; legal range 1..8.
- BINW, 14: binary magnitude output width; must satisfy 2^BINW > 10^DIGITS - 1 (checked by elaboration assertion).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- digit  in  4  BCD digit accompanying load.
- load  in  1  one-cycle strobe: shift digit in at the least significant position.
- bksp  in  1  one-cycle strobe: remove the least significant digit.
- clear  in  1  one-cycle strobe: zero the operand.
- negate  in  1  one-cycle strobe: toggle sign.
- recall  in  1  one-cycle strobe: load recall_bcd and recall_neg.
- recall_bcd  in  4*DIGITS  BCD value to recall; every nibble must be ≤ 9.
- recall_neg  in  1  sign to recall.
- bcd  out  4*DIGITS  operand magnitude in BCD; nibble 0 is least significant.
- neg  out  1  operand sign (1 = negative).
- count  out  4  number of significant digits, 0..DIGITS.
- full  out  1  high when count == DIGITS.
- reject  out  1  one-cycle pulse when a load is refused.
- blank_mask  out  DIGITS  bit i high when nibble i is a leading zero to blank; bit 0 is never set.
- bin  out  BINW  binary magnitude of bcd.
- bin_valid  out  1  high when bin matches the current bcd.
- busy  out  1  converter running.

Behaviour:

Reset (resetn low, asynchronous):
- bcd=0, neg=0, count=0, reject=0, bin=0, bin_valid=1, busy=0. blank_mask follows from count=0.
- Outputs hold these values while resetn is low.
- Release is synchronous to the next clock edge.

Command priority when several strobes share a cycle:
- clear > recall > load > bksp > negate. Only the highest-priority command executes; the others are dropped silently.

Commands:
- clear: bcd=0, neg=0, count=0.
- recall: bcd=recall_bcd, neg=recall_neg, count = index of the highest nonzero nibble + 1 (0 if all nibbles are zero). If recall_bcd is zero, neg is forced to 0.
- load with digit > 9: ignored, reject pulses.
- load while full: ignored, reject pulses.
- load of 0 while count == 0: no state change, no reject (leading zero suppressed).
- load otherwise: bcd = {bcd[4*DIGITS-5:0], digit}, count += 1.
- bksp with count == 0: no-op.
- bksp otherwise: bcd = {4'h0, bcd[4*DIGITS-1:4]}, count -= 1. If count becomes 0, neg is cleared.
- negate with count == 0: ignored.
- negate otherwise: neg toggles.

Derived outputs:
- blank_mask[i] = (i >= count) && (i != 0). Combinational from count.
- full = (count == DIGITS). Combinational.

Converter FSM, states IDLE and RUN:
- Any command that changes bcd is an edit. An edit registered at edge t causes the following at edge t: busy=1, bin_valid=0, accumulator=0, digit index=DIGITS-1, state RUN.
- RUN, one digit per cycle, most significant digit first: acc = acc*10 + nibble[index]; index decrements.
- After DIGITS RUN cycles, at edge t+DIGITS: bin=acc, bin_valid=1, busy=0, state IDLE.
- Latency from edit to bin_valid is DIGITS cycles.
- bin holds its previous value while busy.
- An edit while busy restarts the conversion from the new bcd. No partial result is published.
- negate affects neg only: it does not start a conversion and bin_valid is unchanged.
- A refused or no-op command leaves the converter untouched.
- resetn asserted mid-conversion aborts the conversion to the reset values.

Arithmetic:
- acc is BINW bits wide. acc*10 cannot overflow given the BINW constraint.
- No carries into or out of bcd; all nibble values stay ≤ 9 by construction.

Test Plan:
1. Reset, then load 1,2,3,4: bcd=0x1234, count=4, full=1, blank_mask=0000. Exactly 4 cycles after the last load, bin=1234 and bin_valid=1.
2. Load 5 while full: reject pulses 1 cycle, bcd stays 0x1234. Then load digit 0xA after bksp: bcd=0x0123, count=3, reject pulses, blank_mask=1000.
3. From reset, load 0, 0, 7: bcd=0x0007, count=1, blank_mask=1110, no reject. Then negate gives neg=1 with bin_valid staying 1. Then bksp gives count=0, neg=0, bcd=0.
4. Load 9 immediately followed by load 8 (second load issued while busy): the conversion restarts, no intermediate bin is published, and final bin=98 appears DIGITS cycles after the second load.
5. Assert clear, recall and load in the same cycle with bcd=0x0042: result is bcd=0, count=0. Then recall with recall_bcd=0x0305, recall_neg=1: count=3, neg=1, and after 4 cycles bin=305.
6. Pull resetn low mid-conversion (2 cycles after an edit): bin=0, busy=0 and bin_valid=1 immediately, without waiting for a clock edge. Repeat with DIGITS=8, BINW=27: loading 99999999 gives bin=99999999 after 8 cycles.
